// File: rtl/image_slice_sequencer_if.sv
// Host-stream and decoder-side signal bundle for image_slice_sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface image_slice_sequencer_if #(
    parameter int ROWS  = 8,
    parameter int WIDTH = 8
);
    localparam int SELW = $clog2(ROWS);

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             sof;
    logic             s_ready;
    logic [WIDTH-1:0] slice;
    logic [SELW-1:0]  sel;
    logic             en;
    logic             frame_valid;
    logic             frame_ack;
    logic [7:0]       frame_cnt;
    logic             err;
    logic             err_clr;

    modport master (
        output s_data, s_valid, sof, frame_ack, err_clr,
        input  s_ready, slice, sel, en, frame_valid, frame_cnt, err
    );

    modport slave (
        input  s_data, s_valid, sof, frame_ack, err_clr,
        output s_ready, slice, sel, en, frame_valid, frame_cnt, err
    );
endinterface

// File: rtl/image_slice_sequencer.sv
// Turns a byte-wide row stream into slice/sel/en writes for the image decoder,
// tracking row position, start-of-frame resync and holding each full frame until acked.
module image_slice_sequencer #(
    parameter int ROWS  = 8,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    image_slice_sequencer_if.slave bus
);
    localparam int SELW = $clog2(ROWS);
    localparam logic [SELW-1:0] LAST_ROW = SELW'(ROWS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_FULL   = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [SELW-1:0]  row_reg, row_next;
    logic [WIDTH-1:0] slice_reg;
    logic [SELW-1:0]  sel_reg, issue_sel;
    logic             en_reg, issue;
    logic             frame_valid_reg;
    logic [7:0]       frame_cnt_reg, frame_cnt_next;
    logic             err_reg, err_set;
    logic             ready, beat;

    // Ready depends on state alone so nothing from s_valid loops back combinationally.
    assign ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign beat  = bus.s_valid && ready;

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        issue          = 1'b0;
        issue_sel      = row_reg;
        err_set        = 1'b0;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (beat) begin
                    if (bus.sof) begin
                        issue      = 1'b1;
                        issue_sel  = '0;
                        row_next   = SELW'(1);
                        state_next = ST_LOAD;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    issue = 1'b1;
                    if (bus.sof) begin
                        // Unexpected sof restarts the frame with this beat as row 0.
                        issue_sel = '0;
                        row_next  = SELW'(1);
                        err_set   = 1'b1;
                    end else begin
                        row_next = SELW'(row_reg + 1'b1);
                        if (row_reg == LAST_ROW) begin
                            state_next = ST_SETTLE;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                state_next     = ST_FULL;
                frame_cnt_next = frame_cnt_reg + 8'd1;
            end
            ST_FULL: begin
                if (bus.frame_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            row_reg         <= '0;
            slice_reg       <= '0;
            sel_reg         <= '0;
            en_reg          <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_cnt_reg   <= 8'd0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            row_reg         <= row_next;
            en_reg          <= issue;
            frame_valid_reg <= (state_next == ST_FULL);
            frame_cnt_reg   <= frame_cnt_next;
            if (issue) begin
                slice_reg <= bus.s_data;
                sel_reg   <= issue_sel;
            end
            // A new error in the same cycle as a clear must survive.
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign bus.s_ready     = ready;
    assign bus.slice       = slice_reg;
    assign bus.sel         = sel_reg;
    assign bus.en          = en_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
    assign bus.err         = err_reg;
endmodule

// File: tb/tb_image_slice_sequencer.sv
// Scoreboard bench for image_slice_sequencer: every expected decoder write is queued
// when its beat is accepted and compared when en shows up.
module tb_image_slice_sequencer;
    logic clk;
    logic rst_n;

    image_slice_sequencer_if #(.ROWS(8), .WIDTH(8)) bus ();

    image_slice_sequencer #(.ROWS(8), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    logic [10:0] sb_q[$];
    logic [10:0] sb_entry;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One line per decoder write seen.
    always @(negedge clk) begin
        if (bus.en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("en_unexpected", 32'(bus.en), 32'd0);
            end else begin
                sb_entry = sb_q.pop_front();
                $display("write sel=%0d slice=%02h (exp sel=%0d slice=%02h)",
                         bus.sel, bus.slice, sb_entry[10:8], sb_entry[7:0]);
                check("sel", 32'(bus.sel), 32'(sb_entry[10:8]));
                check("slice", 32'(bus.slice), 32'(sb_entry[7:0]));
            end
        end
    end

    // Called at posedge+1; presents one cycle of stream input.
    task automatic drive(input logic [7:0] d, input logic s, input logic v,
                         input logic exp_rdy, input logic exp_issue, input logic [2:0] exp_sel);
        bus.s_data  = d;
        bus.sof     = s;
        bus.s_valid = v;
        @(negedge clk);
        check("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
        @(posedge clk);
        if (exp_issue) sb_q.push_back({exp_sel, d});
        #1;
        bus.s_valid = 1'b0;
        bus.sof     = 1'b0;
    endtask

    task automatic send_frame();
        for (int r = 0; r < 8; r++) begin
            drive(8'($urandom), (r == 0), 1'b1, 1'b1, 1'b1, 3'(r));
        end
    endtask

    // Called right after the last-row beat.
    task automatic finish_frame(input logic [7:0] exp_cnt, input logic exp_err);
        @(negedge clk);
        #1;
        check("en_latency", 32'(sb_q.size()), 32'd0);
        check("fv_settle", 32'(bus.frame_valid), 32'd0);
        @(negedge clk);
        check("fv_full", 32'(bus.frame_valid), 32'd1);
        check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        check("err", 32'(bus.err), 32'(exp_err));
        check("ready_full", 32'(bus.s_ready), 32'd0);
        $display("frame done cnt=%0d err=%0d", bus.frame_cnt, bus.err);
    endtask

    task automatic ack_frame();
        @(posedge clk);
        #1 bus.frame_ack = 1'b1;
        @(posedge clk);
        #1 bus.frame_ack = 1'b0;
        @(negedge clk);
        check("fv_after_ack", 32'(bus.frame_valid), 32'd0);
        check("ready_after_ack", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_slice"}, 32'(bus.slice), 32'd0);
        check({tag, "_sel"}, 32'(bus.sel), 32'd0);
        check({tag, "_en"}, 32'(bus.en), 32'd0);
        check({tag, "_fv"}, 32'(bus.frame_valid), 32'd0);
        check({tag, "_cnt"}, 32'(bus.frame_cnt), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b1;
        bus.s_data    = '0;
        bus.s_valid   = 1'b0;
        bus.sof       = 1'b0;
        bus.frame_ack = 1'b0;
        bus.err_clr   = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");
        check("reset_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Nominal frame 0x01..0x80
        for (int r = 0; r < 8; r++) begin
            drive(8'(1 << r), (r == 0), 1'b1, 1'b1, 1'b1, 3'(r));
        end
        finish_frame(8'd1, 1'b0);

        // Backpressure while FULL
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            drive(8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            check("fv_hold", 32'(bus.frame_valid), 32'd1);
        end
        ack_frame();

        // Resync at beat 4
        drive(8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        for (int r = 1; r < 4; r++) drive(8'(8'h10 + r), 1'b0, 1'b1, 1'b1, 1'b1, 3'(r));
        drive(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        check("err_resync", 32'(bus.err), 32'd1);
        @(posedge clk);
        #1;
        for (int r = 1; r < 8; r++) drive(8'(8'h20 + r), 1'b0, 1'b1, 1'b1, 1'b1, 3'(r));
        finish_frame(8'd2, 1'b1);
        ack_frame();
        pulse_clr();

        // Stray beats in IDLE
        for (int i = 0; i < 3; i++) drive(8'(8'h30 + i), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        check("err_stray", 32'(bus.err), 32'd1);
        check("ready_stray", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        pulse_clr();
        bus.err_clr = 1'b1;
        drive(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_set_wins", 32'(bus.err), 32'd1);
        @(posedge clk);
        #1;
        pulse_clr();

        // Reset after 5 rows
        for (int r = 0; r < 5; r++) drive(8'(8'h60 + r), (r == 0), 1'b1, 1'b1, 1'b1, 3'(r));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_post_rst", 32'(bus.s_ready), 32'd1);
        check("en_post_rst", 32'(bus.en), 32'd0);
        @(posedge clk);
        #1;
        send_frame();
        finish_frame(8'd1, 1'b0);
        ack_frame();

        // Counter wrap after 256 frames since reset
        for (int f = 2; f <= 256; f++) begin
            send_frame();
            finish_frame(8'(f), 1'b0);
            ack_frame();
        end
        check("cnt_wrapped", 32'(bus.frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
